// File: rtl/vga_rx.sv
// vga_rx: VGA timing receiver with sync measurement and lock tracking.
// Emits registered pixel coordinates and colour once timing is locked.
module vga_rx #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic       blank_n,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       pix_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_LOW  = 10'(H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_LOW  = 10'(V_SYNC);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  state_t     state, state_nxt;
  logic       hs_q, vs_q, bl_q;
  logic [9:0] hcnt, hlow, hwidth;
  logic [9:0] vline, vlow, vwidth;
  logic [9:0] xc, yc;
  logic       acq_bad, lose, fs;
  logic       hs_fall, hs_rise, vs_fall, vs_rise, bl_fall;
  logic       hs_bad, vs_bad;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  assign hs_fall = pix_en & hs_q & ~hsync_n;
  assign hs_rise = pix_en & ~hs_q & hsync_n;
  assign vs_fall = pix_en & vs_q & ~vsync_n;
  assign vs_rise = pix_en & ~vs_q & vsync_n;
  assign bl_fall = pix_en & bl_q & ~blank_n;

  assign hs_bad = hs_fall & ((hcnt != H_LAST) | (hwidth != H_LOW));
  assign vs_bad = vs_fall & ((vline != V_LAST) | (vwidth != V_LOW));

  assign locked = (state == S_LOCKED);

  // previous sample of the sync and blank inputs for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bl_q <= 1'b0;
    end else if (pix_en) begin
      hs_q <= hsync_n;
      vs_q <= vsync_n;
      bl_q <= blank_n;
    end
  end

  // horizontal period counter and hsync low-width measurement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt   <= '0;
      hlow   <= '0;
      hwidth <= '0;
    end else if (pix_en) begin
      hcnt <= hs_fall ? 10'd0 : sat_inc(hcnt);
      if (hs_fall)
        hlow <= 10'd1;
      else if (!hsync_n)
        hlow <= sat_inc(hlow);
      if (hs_rise)
        hwidth <= hlow;
    end
  end

  // line counter and vsync low-width measurement in lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vline  <= '0;
      vlow   <= '0;
      vwidth <= '0;
    end else if (pix_en) begin
      if (vs_fall)
        vline <= '0;
      else if (hs_fall)
        vline <= sat_inc(vline);
      if (vs_fall)
        vlow <= {9'd0, hs_fall};
      else if (!vsync_n && hs_fall)
        vlow <= sat_inc(vlow);
      if (vs_rise)
        vwidth <= vlow;
    end
  end

  // lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_SEARCH;
    else
      state <= state_nxt;
  end

  // next state; lock loss outranks a coincident frame start
  always_comb begin
    state_nxt = state;
    lose      = 1'b0;
    fs        = 1'b0;
    unique case (state)
      S_SEARCH: begin
        if (vs_fall)
          state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (vs_fall && !(acq_bad || hs_bad || vs_bad)) begin
          state_nxt = S_LOCKED;
          fs        = 1'b1;
        end
      end
      S_LOCKED: begin
        if (hs_bad || vs_bad) begin
          state_nxt = S_SEARCH;
          lose      = 1'b1;
        end else if (vs_fall) begin
          fs = 1'b1;
        end
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  // sticky failure flag for the frame being acquired
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acq_bad <= 1'b0;
    else if (vs_fall)
      acq_bad <= 1'b0;
    else if (state == S_ACQUIRE && hs_bad)
      acq_bad <= 1'b1;
  end

  // running coordinates of the next active pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xc <= '0;
      yc <= '0;
    end else if (pix_en) begin
      xc <= blank_n ? sat_inc(xc) : 10'd0;
      if (vs_fall)
        yc <= '0;
      else if (bl_fall)
        yc <= sat_inc(yc);
    end
  end

  // registered pixel output, held between valid strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (pix_en && blank_n && state == S_LOCKED) begin
        pix_valid <= 1'b1;
        x         <= xc;
        y         <= yc;
        r_out     <= r_in;
        g_out     <= g_in;
        b_out     <= b_in;
      end
    end
  end

  // frame and error pulses plus locked-frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= fs;
      timing_err  <= lose;
      if (fs)
        frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: scoreboard bench for vga_rx on a reduced raster.
// 12 ticks/line (sync 2), 8 lines/frame (sync 2), 8x4 active pixels.
module tb_vga_rx;

  localparam int HT = 12;
  localparam int HS = 2;
  localparam int VT = 8;
  localparam int VS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       hsync_n, vsync_n, blank_n;
  logic [7:0] r_in, g_in, b_in;
  logic       pix_valid;
  logic [9:0] x, y;
  logic [7:0] r_out, g_out, b_out;
  logic       frame_start, locked, timing_err;
  logic [7:0] frame_count;

  vga_rx #(
    .H_TOTAL(HT),
    .H_SYNC (HS),
    .V_TOTAL(VT),
    .V_SYNC (VS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .blank_n    (blank_n),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .frame_start(frame_start),
    .locked     (locked),
    .timing_err (timing_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  pix_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   pv_cnt  = 0;
  int   fs_cnt  = 0;
  int   te_cnt  = 0;
  int   gap     = 2;
  int   exp_fc  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops one expected pixel per pix_valid, counts pulses
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
      if (timing_err) te_cnt++;
      if (pix_valid) begin
        pv_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious pix_valid", 64'(x), 64'h3ff_dead);
        end else begin
          e = exp_q.pop_front();
          check("pixel x/y/rgb",
                64'({x, y, r_out, g_out, b_out}), 64'(e));
        end
      end
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic bl,
                      input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    repeat (gap - 1) @(negedge clk);
    pix_en  = 1'b1;
    hsync_n = hs;
    vsync_n = vs;
    blank_n = bl;
    r_in    = r;
    g_in    = g;
    b_in    = b;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // one frame; xl/xn lengthen line xl by xn active ticks,
  // rl asserts reset during line rl; flags give expected behaviour
  task automatic frame(input int vsw, input int xl, input int xn,
                       input int rl, input bit exp_lk,
                       input bit exp_fs, input bit exp_te,
                       input bit pix);
    bit on;
    int len, ext;
    logic hs, vs, bl;
    logic [7:0] r, g, b;
    pix_t e;
    on = pix;
    for (int l = 0; l < VT; l++) begin
      if (xl >= 0 && l == xl + 1) on = 1'b0;
      ext = (l == xl) ? xn : 0;
      len = HT + ext;
      for (int p = 0; p < len; p++) begin
        hs = (p >= HS);
        vs = (l >= vsw);
        bl = (l >= 3 && l < 7 && p >= 3 && p < 11 + ext);
        r  = 8'(p - 3);
        g  = 8'(l - 3);
        b  = 8'(l * 37 + p);
        if (bl && on) begin
          e.x = (p - 3 > 1023) ? 10'd1023 : 10'(p - 3);
          e.y = 10'(l - 3);
          e.r = r;
          e.g = g;
          e.b = b;
          exp_q.push_back(e);
        end
        tick(hs, vs, bl, r, g, b);
        if (l == 0 && p == 0) begin
          if (exp_fs) exp_fc = (exp_fc + 1) % 256;
          check("locked at vsync fall", 64'(locked), 64'(exp_lk));
          check("frame_start", 64'(frame_start), 64'(exp_fs));
          check("timing_err at vsync", 64'(timing_err), 64'(exp_te));
          check("frame_count", 64'(frame_count), 64'(exp_fc));
        end
        if (xl >= 0 && l == xl + 1 && p == 0) begin
          check("timing_err on bad line", 64'(timing_err), 64'd1);
          check("locked after bad line", 64'(locked), 64'd0);
        end
        if (l == rl && p == 5) begin
          #1 reset = 1'b1;
          #1;
          check("outputs in reset",
                64'({pix_valid, x, y, r_out, g_out, b_out,
                     frame_start, locked, timing_err, frame_count}),
                64'd0);
          @(negedge clk);
          reset  = 1'b0;
          on     = 1'b0;
          exp_fc = 0;
        end
      end
    end
  endtask

  initial begin
    int p0, f0, t0;
    reset   = 1'b1;
    pix_en  = 1'b0;
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    blank_n = 1'b0;
    r_in    = '0;
    g_in    = '0;
    b_in    = '0;
    repeat (3) @(negedge clk);
    check("reset state",
          64'({pix_valid, x, y, r_out, g_out, b_out,
               frame_start, locked, timing_err, frame_count}),
          64'd0);
    reset = 1'b0;
    @(negedge clk);

    // acquire then lock; count pixels of the first locked frame
    frame(VS, -1, 0, -1, 0, 0, 0, 0);
    p0 = pv_cnt;
    frame(VS, -1, 0, -1, 1, 1, 0, 1);
    check("pixels per frame", 64'(pv_cnt - p0), 64'd32);
    frame(VS, -1, 0, -1, 1, 1, 0, 1);

    // one line one tick too long
    t0 = te_cnt;
    frame(VS, 4, 1, -1, 1, 1, 0, 1);
    check("timing_err pulses", 64'(te_cnt - t0), 64'd1);
    frame(VS, -1, 0, -1, 0, 0, 0, 0);
    frame(VS, -1, 0, -1, 1, 1, 0, 1);

    // vsync widened to 3 lines
    frame(3, -1, 0, -1, 1, 1, 0, 1);
    frame(VS, -1, 0, -1, 0, 0, 1, 0);
    frame(VS, -1, 0, -1, 0, 0, 0, 0);
    frame(VS, -1, 0, -1, 1, 1, 0, 1);

    // overlong active line: x saturates at 1023
    frame(VS, 4, 1100, -1, 1, 1, 0, 1);
    frame(VS, -1, 0, -1, 0, 0, 0, 0);
    frame(VS, -1, 0, -1, 1, 1, 0, 1);

    // reset mid-frame, then reacquire
    frame(VS, -1, 0, 4, 1, 1, 0, 1);
    frame(VS, -1, 0, -1, 0, 0, 0, 0);

    // 256 locked frames at full pixel rate
    gap = 1;
    f0  = fs_cnt;
    repeat (256) frame(VS, -1, 0, -1, 1, 1, 0, 1);
    check("frame_start count", 64'(fs_cnt - f0), 64'd256);
    check("frame_count wrapped", 64'(frame_count), 64'd0);
    check("timing_err total", 64'(te_cnt), 64'd3);
    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning pixel ticks per line.
REQ-002 SHALL have parameter H_SYNC, default 96, meaning hsync low width in pixel ticks.
REQ-003 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-004 SHALL have parameter V_SYNC, default 2, meaning vsync low width in lines.
REQ-005 SHALL have port clk  in  1  system clock; one clock domain, all inputs synchronous to clk.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port pix_en  in  1  one-clk strobe per pixel tick; all inputs below are sampled only when pix_en=1.
REQ-008 SHALL have port hsync_n, vsync_n  in  1 each  active-low syncs.
REQ-009 SHALL have port blank_n  in  1  high during active video.
REQ-010 SHALL have port r_in, g_in, b_in  in  8 each  pixel colour.
REQ-011 SHALL have port pix_valid  out  1  registered active-pixel strobe.
REQ-012 SHALL have port x, y  out  10 each  coordinates of the pixel qualified by pix_valid.
REQ-013 SHALL have port r_out, g_out, b_out  out  8 each  registered colour.
REQ-014 SHALL have port frame_start  out  1  one-clk pulse per frame.
REQ-015 SHALL have port locked  out  1  timing lock indicator.
REQ-016 SHALL have port timing_err  out  1  one-clk pulse on lock loss.
REQ-017 SHALL have port frame_count  out  8  count of locked frames, wraps 255->0.

Function
REQ-018 SHALL register hsync_n, vsync_n, blank_n on pix_en; hsync/vsync/blank edges = current sample vs previous sample.
REQ-019 SHALL run hcnt: cleared to 0 on the pix_en of an hsync falling edge, else +1 per pix_en, saturating at 1023.
REQ-020 SHALL record hsync low width; hsync check passes iff hcnt = H_TOTAL-1 at the next falling edge and low width = H_SYNC.
REQ-021 SHALL run vline: cleared on a vsync falling edge, else +1 per hsync falling edge, saturating at 1023.
REQ-022 SHALL record vsync low width in lines; vsync check passes iff vline = V_TOTAL-1 at the next vsync falling edge and low width = V_SYNC.
REQ-023 SHALL implement FSM SEARCH -> ACQUIRE -> LOCKED.
REQ-024 In SEARCH, the FSM SHALL go to ACQUIRE on the first vsync falling edge.
REQ-025 In ACQUIRE, the FSM SHALL go to LOCKED at the next vsync falling edge if every hsync and vsync check in the frame passed; otherwise it SHALL stay in ACQUIRE and restart measurement.
REQ-026 In LOCKED, any failed hsync or vsync check SHALL send the FSM to SEARCH and pulse timing_err for one clk.
REQ-027 locked SHALL be 1 iff the FSM is in LOCKED.
REQ-028 x SHALL be 0 for the first blank_n=1 sample of a line and +1 per subsequent blank_n=1 sample; x SHALL clear when blank_n=0.
REQ-029 y SHALL increment on each blank_n falling edge, clear on a vsync falling edge, and be 0 for the first active line.
REQ-030 pix_valid SHALL be 1 for exactly one clk, one clk after a pix_en with blank_n=1 while locked; x, y and colour outputs SHALL update in that same cycle, giving latency 1 clk.
REQ-031 pix_valid SHALL be 0 in SEARCH/ACQUIRE and whenever pix_en=0; the other data outputs SHALL hold their values when pix_valid=0.
REQ-032 frame_start SHALL pulse one clk after a vsync falling edge that occurs while in LOCKED or that causes the ACQUIRE->LOCKED transition.
REQ-033 frame_count SHALL increment on each frame_start and wrap 255->0.
REQ-034 When lock loss and a vsync falling edge occur on the same sample, lock loss SHALL take priority: FSM goes to SEARCH, timing_err=1, frame_start=0.
REQ-035 x and y SHALL saturate at 1023 on overlong lines or frames and SHALL NOT wrap.

Reset
REQ-036 On reset assertion, the FSM SHALL enter SEARCH immediately.
REQ-037 On reset, all counters, x, y, frame_count and colour outputs SHALL be 0.
REQ-038 On reset, pix_valid, frame_start, locked and timing_err SHALL be 0.
REQ-039 On reset, sampled sync history SHALL be 1 and blank history SHALL be 0.
REQ-040 Reset asserted mid-frame SHALL require full reacquisition, i.e. the second vsync falling edge after release before locked=1.

Verification
REQ-041 Drive standard 640x480 timing with pix_en every 2nd clk -> locked=1 one clk after the 2nd vsync falling edge; frame_count=1; 640x480 pix_valid pulses per frame; last pulse has x=639, y=479.
REQ-042 While locked, send one line with H_TOTAL=801 -> timing_err pulses once, locked=0, pix_valid stops; relock at the 2nd subsequent vsync falling edge.
REQ-043 While locked, widen vsync low to 3 lines -> timing_err at the next vsync falling edge; no frame_start on that edge.
REQ-044 Pixel data r_in = x[7:0] -> every pix_valid cycle has r_out = x[7:0]; first pixel of each line has x=0.
REQ-045 Run 256 locked frames -> frame_count wraps to 0; frame_start pulses exactly 256 times.
REQ-046 Assert reset during line 200 -> all outputs 0 in the same cycle; after release, locked only after 2 vsync falling edges.
